// File: rtl/mic_pkg.sv
// Shared types and constants for the mic capture / cross-correlation path.
package mic_pkg;

  typedef enum logic [2:0] {IDLE, CAPTURE, START, FEED, WAIT, DONE} seq_st_e;

  localparam int MIC_FRAME_AW = 9;
  localparam int MIC_PCM_W    = 16;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Wait-cycle counter for the XCORR complete handshake; tc_o fires on the TC-th enabled cycle.
module seq_timeout_cnt #(
  parameter  int TC = 65535,
  localparam int CW = $clog2(TC + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CW-1:0] cnt_q;

  assign tc_o = en_i && (cnt_q == CW'(TC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i)      cnt_q <= '0;
    else if (en_i && !tc_o)  cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/mic_xcorr_seq.sv
// Frame sequencer: captures 2^AW PCM pairs into the sample RAMs, replays them
// into the XCORR core and waits for its completion before re-arming.
module mic_xcorr_seq
  import mic_pkg::*;
#(
  parameter int AW     = MIC_FRAME_AW,
  parameter int DW     = MIC_PCM_W,
  parameter int TO_CYC = 65535
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          xc_en_i,
  input  logic          pcm_vld_i,
  input  logic [DW-1:0] pcm0_i,
  input  logic [DW-1:0] pcm1_i,
  output logic          ram_wea_o,
  output logic [AW-1:0] ram_addra_o,
  output logic [DW-1:0] ram_dina0_o,
  output logic [DW-1:0] ram_dina1_o,
  output logic          ram_ceb_o,
  output logic [AW-1:0] ram_addrb_o,
  output logic          xc_start_o,
  output logic          xc_din_vld_o,
  input  logic          xc_complete_i,
  output logic          busy_o,
  output logic          frame_done_o,
  output logic [7:0]    drop_cnt_o,
  output logic          to_err_o
);

  localparam logic [AW-1:0] LAST = '1;

  seq_st_e       st_q;
  logic [AW-1:0] waddr_q, raddr_q;
  logic          dvld_q, cmpl_prev_q, cmpl_pend_q, en_prev_q, to_err_q;
  logic [7:0]    drop_q, drop_d;
  logic          wea, drop_ev, cmpl_edge, cmpl_hit, tmo_tc;

  assign wea       = pcm_vld_i && (st_q == CAPTURE);
  assign drop_ev   = pcm_vld_i && xc_en_i && (st_q inside {START, FEED, WAIT, DONE});
  assign drop_d    = drop_ev ? sat_inc8(drop_q) : drop_q;
  assign cmpl_edge = xc_complete_i && !cmpl_prev_q;
  // An edge seen while still feeding is held so WAIT can retire it immediately.
  assign cmpl_hit  = cmpl_edge || cmpl_pend_q;

  seq_timeout_cnt #(.TC(TO_CYC)) u_tmo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (st_q != WAIT),
    .en_i  (st_q == WAIT),
    .tc_o  (tmo_tc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q        <= IDLE;
      waddr_q     <= '0;
      raddr_q     <= '0;
      dvld_q      <= 1'b0;
      cmpl_prev_q <= 1'b0;
      cmpl_pend_q <= 1'b0;
      en_prev_q   <= 1'b0;
      to_err_q    <= 1'b0;
      drop_q      <= '0;
    end else begin
      cmpl_prev_q <= xc_complete_i;
      en_prev_q   <= xc_en_i;
      dvld_q      <= (st_q == FEED);
      drop_q      <= drop_d;
      cmpl_pend_q <= (st_q == START || st_q == FEED) && cmpl_hit;
      if (xc_en_i && !en_prev_q) to_err_q <= 1'b0;

      case (st_q)
        IDLE: begin
          waddr_q <= '0;
          raddr_q <= '0;
          if (xc_en_i) st_q <= CAPTURE;
        end
        CAPTURE: begin
          if (!xc_en_i) st_q <= IDLE;
          else if (pcm_vld_i) begin
            waddr_q <= waddr_q + AW'(1);
            if (waddr_q == LAST) st_q <= START;
          end
        end
        START: begin
          if (!xc_en_i) st_q <= IDLE;
          else begin
            raddr_q <= '0;
            st_q    <= FEED;
          end
        end
        FEED: begin
          if (!xc_en_i)             st_q <= IDLE;
          else if (raddr_q == LAST) st_q <= WAIT;
          else                      raddr_q <= raddr_q + AW'(1);
        end
        WAIT: begin
          if (!xc_en_i)     st_q <= IDLE;
          else if (cmpl_hit) st_q <= DONE;
          else if (tmo_tc) begin
            to_err_q <= 1'b1;
            st_q     <= IDLE;
          end
        end
        DONE: begin
          if (xc_en_i) begin
            waddr_q <= '0;
            st_q    <= CAPTURE;
          end else st_q <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign ram_wea_o    = wea;
  assign ram_addra_o  = waddr_q;
  assign ram_dina0_o  = wea ? pcm0_i : '0;
  assign ram_dina1_o  = wea ? pcm1_i : '0;
  assign ram_ceb_o    = (st_q == FEED);
  assign ram_addrb_o  = raddr_q;
  assign xc_start_o   = (st_q == START);
  assign xc_din_vld_o = dvld_q;
  assign busy_o       = (st_q != IDLE);
  assign frame_done_o = (st_q == DONE);
  assign drop_cnt_o   = drop_q;
  assign to_err_o     = to_err_q;

endmodule

// File: tb/tb_mic_xcorr_seq.sv
// Directed bench for mic_xcorr_seq: frame flow, drops, aborts, timeout, early complete, reset.
module tb_mic_xcorr_seq;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst, xc_en, pcm_vld, xc_complete;
  logic [DW-1:0] pcm0, pcm1;
  logic          ram_wea, ram_ceb, xc_start, xc_din_vld, busy, frame_done, to_err;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina0, ram_dina1;
  logic [7:0]    drop_cnt;

  mic_xcorr_seq #(.AW(AW), .DW(DW), .TO_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst), .xc_en_i(xc_en), .pcm_vld_i(pcm_vld),
    .pcm0_i(pcm0), .pcm1_i(pcm1),
    .ram_wea_o(ram_wea), .ram_addra_o(ram_addra),
    .ram_dina0_o(ram_dina0), .ram_dina1_o(ram_dina1),
    .ram_ceb_o(ram_ceb), .ram_addrb_o(ram_addrb),
    .xc_start_o(xc_start), .xc_din_vld_o(xc_din_vld), .xc_complete_i(xc_complete),
    .busy_o(busy), .frame_done_o(frame_done), .drop_cnt_o(drop_cnt), .to_err_o(to_err)
  );

  always #5 clk = ~clk;

  // external RAM model and event counters, sampled mid-cycle
  logic [DW-1:0] mem0 [512];
  logic [DW-1:0] mem1 [512];
  int cyc, n_wr, n_start, n_ceb, n_dvld, n_done, seq_err, start_cyc, first_ceb_cyc, ceb_idx;

  always @(negedge clk) begin
    cyc++;
    if (ram_wea) begin
      mem0[ram_addra] = ram_dina0;
      mem1[ram_addra] = ram_dina1;
      n_wr++;
    end
    if (xc_start) begin
      n_start++;
      start_cyc = cyc;
      ceb_idx = 0;
    end
    if (ram_ceb) begin
      if (int'(ram_addrb) != ceb_idx) seq_err++;
      if (ceb_idx == 0) first_ceb_cyc = cyc;
      ceb_idx++;
      n_ceb++;
    end
    if (xc_din_vld) n_dvld++;
    if (frame_done) n_done++;
  end

  int n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk); #1;
  endtask

  function automatic logic [15:0] p0(input int sel, input int k);
    return (sel == 0) ? 16'(k) : (16'(k) ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] p1(input int sel, input int k);
    return (sel == 0) ? 16'(-k) : ~16'(k);
  endfunction

  function automatic int mem_err(input int sel);
    int e = 0;
    for (int a = 0; a < 512; a++)
      if (mem0[a] !== p0(sel, a) || mem1[a] !== p1(sel, a)) e++;
    return e;
  endfunction

  // one strobe per gap cycles; returns on the cycle after the last strobe
  task automatic cap(input int k0, input int n, input int sel, input int gap);
    for (int k = k0; k < k0 + n; k++) begin
      pcm_vld = 1'b1;
      pcm0 = p0(sel, k);
      pcm1 = p1(sel, k);
      step();
      pcm_vld = 1'b0;
      if (k != k0 + n - 1) repeat (gap - 1) step();
    end
  endtask

  task automatic wait_start;
    bit hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      smp();
      hit = xc_start;
    end
    if (!hit) chk("tmo_start", 0, 1);
  endtask

  task automatic wait_ceb(input int a);
    bit hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      smp();
      hit = ram_ceb && (int'(ram_addrb) == a);
    end
    if (!hit) chk("tmo_ceb", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s_wr, s_start, s_ceb, s_dvld, s_done, s_seq, bad;
    rst = 1'b1; xc_en = 1'b0; pcm_vld = 1'b0; xc_complete = 1'b0;
    pcm0 = 16'h1111; pcm1 = 16'h2222;
    repeat (3) step();
    smp();
    chk("rst_busy", busy, 0);
    chk("rst_wea", ram_wea, 0);
    chk("rst_ceb", ram_ceb, 0);
    chk("rst_start", xc_start, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_toerr", to_err, 0);
    chk("rst_dina0", ram_dina0, 0);
    rst = 1'b0;
    step();

    // strobes in IDLE and on the CAPTURE entry cycle are neither written nor counted
    pcm_vld = 1'b1; pcm0 = 16'h5555;
    smp();
    chk("idle_wea", ram_wea, 0);
    step(); step();
    xc_en = 1'b1; pcm0 = 16'h7777;
    smp();
    chk("entry_wea", ram_wea, 0);
    step();
    pcm_vld = 1'b0;
    smp();
    chk("cap_busy", busy, 1);
    chk("cap_addr0", ram_addra, 0);
    step();

    // basic ramp frame, slow strobes
    s_wr = n_wr; s_start = n_start; s_ceb = n_ceb; s_dvld = n_dvld; s_done = n_done; s_seq = seq_err;
    cap(0, 512, 0, 64);
    wait_start();
    wait_ceb(511);
    step();
    repeat (19) step();
    xc_complete = 1'b1;
    step();
    xc_complete = 1'b0;
    smp();
    chk("b_done", frame_done, 1);
    step(); smp();
    chk("b_done_1cyc", frame_done, 0);
    chk("b_recap", busy, 1);
    chk("b_recap_addr", ram_addra, 0);
    chk("b_start_n", n_start - s_start, 1);
    chk("b_ceb_n", n_ceb - s_ceb, 512);
    chk("b_dvld_n", n_dvld - s_dvld, 512);
    chk("b_done_n", n_done - s_done, 1);
    chk("b_ceb_seq", seq_err - s_seq, 0);
    chk("b_start_lead", first_ceb_cyc - start_cyc, 1);
    chk("b_wr_n", n_wr - s_wr, 512);
    chk("b_ram", mem_err(0), 0);
    chk("b_mem1_5", mem1[5], 16'hFFFB);
    chk("b_mem0_300", mem0[300], 16'h012C);
    step();

    // three drops during FEED
    s_wr = n_wr;
    cap(0, 512, 1, 1);
    wait_start();
    step();
    repeat (3) begin
      pcm_vld = 1'b1; pcm0 = 16'hDEAD; pcm1 = 16'hBEEF;
      step();
      pcm_vld = 1'b0;
      step();
    end
    wait_ceb(511);
    step();
    repeat (4) step();
    xc_complete = 1'b1;
    step();
    xc_complete = 1'b0;
    smp();
    chk("d_done", frame_done, 1);
    chk("d_drop3", drop_cnt, 3);
    chk("d_wr_n", n_wr - s_wr, 512);
    chk("d_ram", mem_err(1), 0);
    chk("d_mem0_3", mem0[3], 16'h5A59);
    chk("d_mem1_3", mem1[3], 16'hFFFC);
    step();

    // 300 drops saturate; complete pulsed early during FEED
    s_wr = n_wr;
    cap(0, 512, 0, 1);
    wait_start();
    step();
    pcm_vld = 1'b1; pcm0 = 16'hDEAD;
    repeat (300) step();
    pcm_vld = 1'b0;
    smp();
    chk("d_drop_sat", drop_cnt, 255);
    xc_complete = 1'b1;
    step();
    xc_complete = 1'b0;
    wait_ceb(511);
    step(); smp();
    chk("e_w1_nodone", frame_done, 0);
    chk("e_w1_busy", busy, 1);
    step(); smp();
    chk("e_done", frame_done, 1);
    chk("e_wr_n", n_wr - s_wr, 512);
    step();

    // abort mid-capture, then restart from address 0
    cap(0, 200, 0, 1);
    s_start = n_start;
    xc_en = 1'b0;
    step(); smp();
    chk("a_idle", busy, 0);
    repeat (5) step();
    chk("a_no_start", n_start - s_start, 0);
    xc_en = 1'b1;
    step(); smp();
    chk("a_rearm_busy", busy, 1);
    chk("a_rearm_addr", ram_addra, 0);
    step();
    pcm_vld = 1'b1; pcm0 = 16'h1234; pcm1 = 16'h4321;
    smp();
    chk("a_wea", ram_wea, 1);
    chk("a_waddr0", ram_addra, 0);
    chk("a_dina0", ram_dina0, 16'h1234);
    step();
    pcm_vld = 1'b0;
    smp();
    chk("a_waddr1", ram_addra, 1);
    step();

    // abort in FEED at read address 100
    cap(1, 511, 0, 1);
    wait_start();
    wait_ceb(100);
    s_done = n_done;
    xc_en = 1'b0;
    step(); smp();
    chk("f_ceb_off", ram_ceb, 0);
    chk("f_idle", busy, 0);
    repeat (5) step();
    chk("f_no_done", n_done - s_done, 0);
    chk("f_mem0_0", mem0[0], 16'h1234);
    chk("f_mem0_1", mem0[1], 16'h0001);

    // timeout: complete never arrives
    xc_en = 1'b1;
    step();
    cap(0, 512, 0, 1);
    wait_start();
    wait_ceb(511);
    s_done = n_done;
    bad = 0;
    for (int k = 1; k <= TO; k++) begin
      step(); smp();
      if (to_err || !busy) bad++;
    end
    chk("t_wait_hold", bad, 0);
    step(); smp();
    chk("t_err_set", to_err, 1);
    chk("t_idle", busy, 0);
    chk("t_no_done", n_done - s_done, 0);
    xc_en = 1'b0;
    step(); smp();
    chk("t_err_sticky", to_err, 1);
    xc_en = 1'b1;
    step(); smp();
    chk("t_err_clr", to_err, 0);
    chk("t_recap", busy, 1);
    step();

    // synchronous reset mid-FEED
    cap(0, 512, 0, 1);
    wait_start();
    repeat (10) step();
    pcm0 = 16'hABCD;
    rst = 1'b1;
    step(); smp();
    chk("r_busy", busy, 0);
    chk("r_ceb", ram_ceb, 0);
    chk("r_dvld", xc_din_vld, 0);
    chk("r_addrb", ram_addrb, 0);
    chk("r_addra", ram_addra, 0);
    chk("r_drop", drop_cnt, 0);
    chk("r_done", frame_done, 0);
    chk("r_dina0", ram_dina0, 0);
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
